// File: rtl/uart_rcv.sv
// 8N1 UART receiver: two-flop RX synchronizer, mid-bit sampling FSM, sticky
// rdy/frm_err handshake with the downstream consumer.
module uart_rcv #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [11:0] BIT_RELOAD  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_RELOAD = 12'(BAUD_DIV / 2 - 1);

  logic        rx_meta_r;
  logic        rx_s;
  logic [1:0]  state_r;
  logic [11:0] baud_cnt_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic        sample_s;
  logic        start_det_s;
  logic        stop_set_s;

  // Decode of sample strobe, start detect and end-of-frame event
  always_comb begin
    sample_s    = (baud_cnt_r == 12'd0);
    start_det_s = (state_r == IDLE) && !rx_s;
    stop_set_s  = (state_r == STOP) && sample_s;
  end

  // Two-flop synchronizer for the asynchronous RX pin
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_s      <= rx_meta_r;
    end
  end

  // Bit-period counter; half-period load on start detect aligns samples mid-bit
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_r <= 12'd0;
    end else if (start_det_s) begin
      baud_cnt_r <= HALF_RELOAD;
    end else if (sample_s) begin
      baud_cnt_r <= BIT_RELOAD;
    end else if (state_r != IDLE) begin
      baud_cnt_r <= baud_cnt_r - 12'd1;
    end else begin
      baud_cnt_r <= baud_cnt_r;
    end
  end

  // Frame FSM, bit counter and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (sample_s) begin
            bit_cnt_r <= 4'd0;
            state_r   <= rx_s ? IDLE : DATA;
          end else begin
            state_r <= START;
          end
        end
        DATA: begin
          if (sample_s) begin
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            state_r   <= (bit_cnt_r == 4'd7) ? STOP : DATA;
          end else begin
            state_r <= DATA;
          end
        end
        STOP: begin
          // Leaving mid-stop-bit lets back-to-back frames be caught without a gap
          if (sample_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= STOP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output byte and sticky flags; a frame completion wins over any clear
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else if (stop_set_s) begin
      rx_data <= shift_r;
      rdy     <= 1'b1;
      frm_err <= ~rx_s;
    end else if (clr_rdy || start_det_s) begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rdy     <= rdy;
      frm_err <= frm_err;
    end
  end

endmodule

// File: tb/tb_uart_rcv.sv
// Scoreboard bench for uart_rcv at 16 clocks per bit: frames push expected
// byte/flag/edge, an independent monitor checks each rising rdy.
module tb_uart_rcv;

  localparam int DIV = 16;
  // Edges from driving the start bit on the pin to the rdy rising edge
  localparam int LAT = 1 + 2 + DIV / 2 + 9 * DIV;

  logic       clk;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  logic prev_rdy = 1'b0;

  uart_rcv #(.BAUD_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @edge %0d", name, act, exp, edge_n);
    end
  endtask

  // Drive one frame from a negedge; stop bit value selectable
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    exp_t e;
    e.data    = d;
    e.ferr    = ~stop_bit;
    e.edge_no = edge_n + LAT;
    exp_q.push_back(e);
    RX = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (DIV) @(negedge clk);
    end
    RX = stop_bit;
    repeat (DIV) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  // Monitor: every rising rdy must match the head of the scoreboard
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (rdy && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rdy", 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("frm_err", 32'(frm_err), 32'(e.ferr));
          check("rdy_edge", 32'(edge_n), 32'(e.edge_no));
        end
      end
      prev_rdy = rdy;
    end
  end

  initial begin
    int t0;
    rst     = 1'b1;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_frm_err", 32'(frm_err), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    repeat (500) @(negedge clk);
    check("idle_rdy", 32'(rdy), 32'd0);

    // Single byte, then acknowledge
    send_byte(8'h67, 1'b1);
    check("single_rdy", 32'(rdy), 32'd1);
    pulse_clr();
    check("clr_rdy_low", 32'(rdy), 32'd0);
    check("clr_data_hold", 32'(rx_data), 32'h67);
    repeat (20) @(negedge clk);

    // Back-to-back frames without acknowledge
    send_byte(8'h73, 1'b1);
    check("b2b_first_rdy", 32'(rdy), 32'd1);
    check("b2b_first_data", 32'(rx_data), 32'h73);
    send_byte(8'hA5, 1'b1);
    pulse_clr();
    repeat (20) @(negedge clk);

    // Framing error, then a good frame clears the flag
    send_byte(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    send_byte(8'h00, 1'b1);
    check("ferr_clear_flag", 32'(frm_err), 32'd0);
    pulse_clr();
    repeat (20) @(negedge clk);

    // Short low glitch must be rejected
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rdy", 32'(rdy), 32'd0);
    check("glitch_fsm_idle", 32'(dut.state_r), 32'd0);

    // Reset during bit 4 of 8'hFF aborts the frame
    RX = 1'b0;
    repeat (DIV) @(negedge clk);
    RX = 1'b1;
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_fsm_idle", 32'(dut.state_r), 32'd0);
    repeat (40) @(negedge clk);
    check("abort_rdy", 32'(rdy), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'h00);
    send_byte(8'h3C, 1'b1);
    pulse_clr();
    repeat (20) @(negedge clk);

    // clr_rdy held across the STOP sample: set wins, clear follows
    t0 = edge_n;
    fork
      send_byte(8'h81, 1'b1);
      begin
        while (edge_n < t0 + LAT - 2) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("simul_set_wins", 32'(rdy), 32'd1);
        @(negedge clk);
        check("simul_then_clear", 32'(rdy), 32'd0);
        clr_rdy = 1'b0;
      end
    join

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rcv.md
# uart_rcv

Serial receiver feeding the authorization block on the DE0 bring-up. It recovers 8N1 UART frames from the RX line driven by the board transmitter or the phone BLE module. It presents each byte as `rx_data` with a sticky `rdy` flag, which the authorization FSM consumes and acknowledges via `clr_rdy`. The block also reports framing errors so the authorization logic can ignore corrupted bytes; this replaces the `'g'`/`'s'` command decode path's dependency on an external receiver.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit (50 MHz / 19200 baud); must be an even value ≥ 8.
- `clk`  input  1  system clock, 50 MHz, all logic on rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `RX`  input  1  asynchronous serial line, idle high.
- `clr_rdy`  input  1  consumer acknowledge; clears `rdy` on the next edge.
- `rx_data`  output  8  last received byte, LSB received first.
- `rdy`  output  1  byte available; sticky until cleared.
- `frm_err`  output  1  last frame had stop bit = 0; valid while `rdy` = 1.

## Operation
- **RX synchronizer:** two flops, both forced to 1 by `rst`. Only the second flop (`rx_s`) is used by the logic.
- **Bit-period counter:** `baud_cnt`, a 12-bit down-counter. A "sample" occurs on the edge where `baud_cnt` == 0; on that edge it reloads `BAUD_DIV-1`. Otherwise it decrements while the FSM is not IDLE.
- **Bit counter:** `bit_cnt`, 4 bits, counts data bits 0..8.
- **Shift register:** 8 bits, shifts right, with `rx_s` entering at bit 7. After 8 shifts, bit 0 holds the first data bit.
- **FSM states:**
  - IDLE: `rx_s` == 0 → START. Load `baud_cnt` = `BAUD_DIV/2 - 1` and clear `rdy`, so a new start bit discards an unacknowledged byte.
  - START: at sample, `rx_s` == 1 → IDLE (glitch/false start, no output change). Otherwise → DATA with `bit_cnt` = 0.
  - DATA: at each sample, shift and increment `bit_cnt`. The sample with `bit_cnt` == 7 → STOP.
  - STOP: at sample, copy the shift register to `rx_data`, set `rdy` = 1 and `frm_err` = ~`rx_s`, then → IDLE.
    - The return to IDLE happens mid-stop-bit, so back-to-back frames are received with no gap required.
- **`rdy` priority:** set (STOP sample) > clear (`clr_rdy` or start detect). A `clr_rdy` on the same edge as the STOP sample is ignored.
- **Framing errors:** `rx_data` is still updated on a framing error. `frm_err` is cleared together with `rdy`.
- **Reset mid-frame:** immediately → IDLE on the edge `rst` is sampled high. The partial byte is discarded.

## Timing
- **Reset values:**
  - `rx_data` = 8'h00, `rdy` = 0, `frm_err` = 0.
  - FSM = IDLE, `baud_cnt` = 0, `bit_cnt` = 0, shift register = 0, synchronizer flops = 1.
- **Start detection:** edge E0 is the first edge where `rx_s` is 0. The FSM enters START at E0 + 1.
- **Sample points:**
  - The start-bit sample lands `BAUD_DIV/2` edges after E0 + 1.
  - Each later sample follows exactly `BAUD_DIV` edges after the previous one.
- **Output latency:** `rdy` and `rx_data` update on edge E0 + 1 + `BAUD_DIV/2` + 9·`BAUD_DIV`.
- **`clr_rdy`:** `rdy` falls on the edge `clr_rdy` is sampled high (single-cycle pulse sufficient; holding it high is harmless).
- **Pin-to-sync delay:** RX pin → `rx_s` is 2 cycles; add this when measuring from the pin.
- **Glitch rejection:** a low glitch shorter than `BAUD_DIV/2` cycles is rejected in START.
- **Baud tolerance:** mid-bit sampling tolerates ±4% baud mismatch.

## Test plan
All scenarios use `BAUD_DIV` = 16 on the bench.
- **Reset:** assert `rst` 3 cycles with RX = 1 → `rdy` = 0, `frm_err` = 0, `rx_data` = 8'h00; RX held high for 500 cycles → `rdy` stays 0.
- **Single byte:** send 8'h67 ('g') at exactly 16 cycles/bit with valid stop → `rdy` rises once, `rx_data` = 8'h67, `frm_err` = 0.
  - `rdy` rises on edge E0 + 1 + 8 + 144.
  - `clr_rdy` pulse → `rdy` = 0 the next edge; `rx_data` holds 8'h67.
- **Back-to-back frames:** send 8'h73 ('s') immediately followed by 8'hA5, stop bits of exactly 16 cycles, no `clr_rdy`.
  - `rdy` high after the first frame with `rx_data` = 8'h73.
  - `rdy` drops at the second start detect, then rises with `rx_data` = 8'hA5.
- **Framing error:** send 8'h55 with stop bit driven 0 → `rdy` = 1, `rx_data` = 8'h55, `frm_err` = 1.
  - A following good frame 8'h00 → `frm_err` = 0.
- **False start and reset abort:**
  - RX low pulse of 5 cycles → FSM returns to IDLE; `rdy` never asserts.
  - Separately, `rst` asserted during bit 4 of 8'hFF → IDLE, `rdy` = 0; the next full frame 8'h3C is received correctly.
- **Simultaneous events:** `clr_rdy` held high across the STOP sample of 8'h81 → `rdy` = 1 after that edge (set wins), then cleared one edge later.
